// File: rtl/fifo_move_sequencer_if.sv
// Bus between the move sequencer, its move FIFO, the start control and the stepper driver.
// The master side drives control and FIFO data; the slave side is the sequencer.
interface fifo_move_sequencer_if #(
  parameter int unsigned DATO_WIDTH = 3
);
  logic                  enable;
  logic                  fifo_empty;
  logic [DATO_WIDTH-1:0] fifo_datout;
  logic                  fifo_rd;
  logic                  step;
  logic                  dir;
  logic                  busy;
  logic                  done;

  modport master (
    output enable, fifo_empty, fifo_datout,
    input  fifo_rd, step, dir, busy, done
  );

  modport slave (
    input  enable, fifo_empty, fifo_datout,
    output fifo_rd, step, dir, busy, done
  );
endinterface

// File: rtl/fifo_move_sequencer.sv
// Pops quarter-turn move codes from a FIFO and plays each one out as a timed
// dir/step pulse train for a stepper driver.
module fifo_move_sequencer #(
  parameter int unsigned DATO_WIDTH        = 3,
  parameter int unsigned STEPS_PER_QUARTER = 50,
  parameter int unsigned PULSE_CYCLES      = 1000,
  parameter int unsigned SETUP_CYCLES      = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_move_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = 12;
  localparam int unsigned TMR_W = 16;

  localparam logic [TMR_W-1:0] SETUP_RELOAD = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] PULSE_RELOAD = TMR_W'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_SETUP,
    S_STEP_HI,
    S_STEP_LO,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             dir_q, dir_d;
  logic             fifo_rd_q, fifo_rd_d;
  logic             step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0]       quarters;
  logic             tmr_zero;
  logic [CNT_W-1:0] total_steps;

  // Move code is sampled straight off the FIFO during LOAD (read data valid the cycle after fifo_rd).
  assign quarters    = bus.fifo_datout[1:0];
  assign tmr_zero    = (tmr_q == '0);
  assign total_steps = CNT_W'(quarters) * CNT_W'(STEPS_PER_QUARTER);

  // State register; ready_q holds off the first pop until the second edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (ready_q && bus.enable && !bus.fifo_empty) state_d = S_POP;
      S_POP:     state_d = S_LOAD;
      S_LOAD:    state_d = (quarters == 2'd0) ? S_DONE : S_SETUP;
      S_SETUP:   if (tmr_zero) state_d = S_STEP_HI;
      S_STEP_HI: if (tmr_zero) state_d = S_STEP_LO;
      S_STEP_LO: if (tmr_zero) state_d = (cnt_q != '0) ? S_STEP_HI : S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Timer, step counter and direction next values.
  always_comb begin
    tmr_d = tmr_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    unique case (state_q)
      S_LOAD: begin
        dir_d = bus.fifo_datout[2];
        cnt_d = total_steps;
        tmr_d = SETUP_RELOAD;
      end
      S_SETUP, S_STEP_LO: begin
        tmr_d = tmr_zero ? PULSE_RELOAD : tmr_q - TMR_W'(1);
      end
      S_STEP_HI: begin
        if (tmr_zero) begin
          tmr_d = PULSE_RELOAD;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from the next state so the registered copies line up with the state.
  always_comb begin
    fifo_rd_d = (state_d == S_POP);
    step_d    = (state_d == S_STEP_HI);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      tmr_q     <= '0;
      dir_q     <= 1'b0;
      fifo_rd_q <= 1'b0;
      step_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      dir_q     <= dir_d;
      fifo_rd_q <= fifo_rd_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.fifo_rd = fifo_rd_q;
  assign bus.step    = step_q;
  assign bus.dir     = dir_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_fifo_move_sequencer.sv
// Bench for fifo_move_sequencer: FIFO model, per-cycle move-schedule model and directed moves.
module tb_fifo_move_sequencer;

  localparam int SPQ = 2;
  localparam int PC  = 3;
  localparam int SC  = 2;

  logic clk = 1'b0;
  logic rst;

  fifo_move_sequencer_if #(.DATO_WIDTH(3)) bus ();

  fifo_move_sequencer #(
    .DATO_WIDTH       (3),
    .STEPS_PER_QUARTER(SPQ),
    .PULSE_CYCLES     (PC),
    .SETUP_CYCLES     (SC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // External move FIFO: registered read data, empty flag updated on the clock.
  logic [2:0] fq[$];
  logic [2:0] mq[$];

  always @(posedge clk) begin
    if (bus.fifo_rd && fq.size() > 0) bus.fifo_datout <= fq.pop_front();
    bus.fifo_empty <= (fq.size() == 0);
  end

  task automatic push(input logic [2:0] code);
    fq.push_back(code);
    mq.push_back(code);
  endtask

  // Move model: each popped code becomes a fixed timeline measured from its POP cycle.
  bit         m_active   = 0;
  bit         m_pend     = 0;
  bit         m_ready    = 0;
  bit         m_dir      = 0;
  bit         m_dir_new  = 0;
  int         m_k        = 0;
  int         m_n        = 0;
  int         m_t        = 0;
  logic [2:0] m_code;

  int rd_count = 0, pulse_count = 0, done_count = 0;
  int pop_cyc = 0, done_cyc = 0;
  logic prev_step = 1'b0;

  always @(negedge clk) begin
    logic e_rd, e_step, e_busy, e_done;
    int   base;
    e_rd = 0; e_step = 0; e_busy = 0; e_done = 0;
    if (rst) begin
      m_active = 0; m_pend = 0; m_ready = 0; m_dir = 0;
    end else begin
      if (m_pend) begin
        m_code    = mq.pop_front();
        m_n       = int'(m_code[1:0]) * SPQ;
        m_t       = (m_n == 0) ? 2 : 2 + SC + 2 * PC * m_n;
        m_dir_new = m_code[2];
        m_k       = 0;
        m_active  = 1;
        m_pend    = 0;
      end
      if (m_active) begin
        base   = 2 + SC;
        e_rd   = (m_k == 0);
        e_busy = 1;
        e_done = (m_k == m_t);
        e_step = (m_n > 0) && (m_k >= base) && (m_k < base + 2 * PC * m_n)
                 && (((m_k - base) % (2 * PC)) < PC);
        if (m_k == 2) m_dir = m_dir_new;
      end
    end
    chk("fifo_rd", 32'(bus.fifo_rd), 32'(e_rd));
    chk("step",    32'(bus.step),    32'(e_step));
    chk("busy",    32'(bus.busy),    32'(e_busy));
    chk("done",    32'(bus.done),    32'(e_done));
    chk("dir",     32'(bus.dir),     32'(m_dir));
    if (!rst) begin
      if (m_active) begin
        if (m_k == m_t) m_active = 0;
        else m_k++;
      end else begin
        if (m_ready && bus.enable && !bus.fifo_empty) m_pend = 1;
        m_ready = 1;
      end
      if (bus.fifo_rd) begin rd_count++; pop_cyc = cyc; end
      if (bus.step && !prev_step) pulse_count++;
      if (bus.done) begin done_count++; done_cyc = cyc; end
    end
    prev_step = bus.step;
  end

  task automatic wait_done(input string nm, input int budget);
    int start;
    start = done_count;
    for (int i = 0; i < budget && done_count == start; i++) @(posedge clk);
    #2;
    chk({nm, "_done_seen"}, 32'(done_count - start), 32'd1);
  endtask

  task automatic run_move(input string nm, input int pulses, input int lat, input int d);
    int p0, r0;
    p0 = pulse_count;
    r0 = rd_count;
    wait_done(nm, 200);
    chk({nm, "_pulses"},  32'(pulse_count - p0), 32'(pulses));
    chk({nm, "_latency"}, 32'(done_cyc - pop_cyc), 32'(lat));
    chk({nm, "_dir"},     32'(bus.dir), 32'(d));
    chk({nm, "_reads"},   32'(rd_count - r0), 32'd1);
  endtask

  initial begin
    int p0, r0, d1, rel;
    rst = 1'b1;
    bus.enable = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
    chk("rst_step",    32'(bus.step),    32'd0);
    chk("rst_dir",     32'(bus.dir),     32'd0);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_done",    32'(bus.done),    32'd0);
    rst = 1'b0;

    // Disabled with a non-empty FIFO: nothing is popped.
    push(3'b001);
    repeat (10) @(posedge clk);
    #2;
    chk("disabled_reads", 32'(rd_count), 32'd0);
    chk("disabled_busy",  32'(bus.busy), 32'd0);

    bus.enable = 1'b1;
    run_move("m001", 2, 16, 0);
    push(3'b111);
    run_move("m111", 6, 40, 1);
    push(3'b100);
    run_move("m100", 0, 2, 1);

    // Back-to-back moves from a pre-loaded FIFO.
    bus.enable = 1'b0;
    push(3'b001);
    push(3'b010);
    repeat (2) @(posedge clk);
    #2;
    bus.enable = 1'b1;
    r0 = rd_count;
    p0 = pulse_count;
    wait_done("b2b_first", 200);
    chk("b2b_first_pulses", 32'(pulse_count - p0), 32'd2);
    d1 = done_cyc;
    p0 = pulse_count;
    wait_done("b2b_second", 200);
    chk("b2b_second_pulses",  32'(pulse_count - p0), 32'd4);
    chk("b2b_gap",            32'(pop_cyc - d1), 32'd2);
    chk("b2b_reads",          32'(rd_count - r0), 32'd2);
    chk("b2b_second_latency", 32'(done_cyc - pop_cyc), 32'd28);

    // Enable dropped mid-move: the move still completes.
    push(3'b010);
    for (int i = 0; i < 20 && !bus.busy; i++) begin @(posedge clk); #2; end
    chk("drop_busy_seen", 32'(bus.busy), 32'd1);
    p0 = pulse_count;
    repeat (5) @(posedge clk);
    #2;
    bus.enable = 1'b0;
    wait_done("drop", 200);
    chk("drop_latency", 32'(done_cyc - pop_cyc), 32'd28);
    chk("drop_reads_after", 32'(bus.busy), 32'd0);
    bus.enable = 1'b1;

    // Reset during STEP_HI of a 3'b011 move; next entry 3'b001 follows.
    push(3'b011);
    push(3'b001);
    for (int i = 0; i < 50 && !bus.step; i++) begin @(posedge clk); #2; end
    chk("rstmid_step_seen", 32'(bus.step), 32'd1);
    @(posedge clk);
    #2;
    d1 = done_count;
    r0 = rd_count;
    rst = 1'b1;
    #1;
    chk("rstmid_step_async", 32'(bus.step), 32'd0);
    chk("rstmid_busy_async", 32'(bus.busy), 32'd0);
    chk("rstmid_dir_async",  32'(bus.dir),  32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    rel = cyc;
    p0 = pulse_count;
    wait_done("rstmid_next", 200);
    chk("rstmid_no_abandoned_done", 32'(done_count - d1), 32'd1);
    chk("rstmid_first_pop_delay",   32'(pop_cyc - rel), 32'd2);
    chk("rstmid_next_pulses",       32'(pulse_count - p0), 32'd2);
    chk("rstmid_next_latency",      32'(done_cyc - pop_cyc), 32'd16);
    chk("rstmid_reads",             32'(rd_count - r0), 32'd1);
    chk("rstmid_fifo_drained",      32'(fq.size()), 32'd0);

    repeat (5) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
